// File: rtl/rc4_decipher_if.sv
// rc4_decipher_if
//   Groups the three streams of the RC4 decipher into one bundle:
//     key_byte / key_valid / key_ready   password bytes into the block
//     ct_data / ct_valid / ct_last / ct_ready   ciphertext bytes into the block
//     pt_data / pt_valid / pt_last / pt_ready   plaintext bytes out of the block
//     init_done                          key schedule finished, keystream ready
//   The slave modport is the decipher's view; the master modport is the view of
//   whatever feeds keys and ciphertext and consumes plaintext.
interface rc4_decipher_if;
  logic [7:0] key_byte;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] ct_data;
  logic       ct_valid;
  logic       ct_last;
  logic       ct_ready;
  logic [7:0] pt_data;
  logic       pt_valid;
  logic       pt_last;
  logic       pt_ready;
  logic       init_done;

  modport slave (
    input  key_byte, key_valid, ct_data, ct_valid, ct_last, pt_ready,
    output key_ready, ct_ready, pt_data, pt_valid, pt_last, init_done
  );

  modport master (
    output key_byte, key_valid, ct_data, ct_valid, ct_last, pt_ready,
    input  key_ready, ct_ready, pt_data, pt_valid, pt_last, init_done
  );
endinterface

// File: rtl/rc4_decipher.sv
// rc4_decipher
//   RC4 stream decipher. Accepts KEY_LEN password bytes, rebuilds the S-box
//   (256-cycle fill followed by the 256-cycle key schedule), then XORs each
//   incoming ciphertext byte with the next keystream byte. The keystream keeps
//   running across bytes of a message; the byte flagged ct_last ends the
//   message and the block goes back to waiting for a fresh key.
//
//   Parameters
//     KEY_LEN   password bytes per key (1..16)
//   Ports
//     clk       rising-edge clock
//     rst       synchronous, active-low reset
//     bus       rc4_decipher_if.slave: key, ciphertext and plaintext streams,
//               plus init_done
//
//   Each ciphertext byte takes a fixed four edges from accept to pt_valid:
//   GEN_J, SWAP and two cycles of KS, after which the byte sits in OUT until
//   pt_ready is seen.
module rc4_decipher #(
  parameter int KEY_LEN = 8
) (
  input logic           clk,
  input logic           rst,
  rc4_decipher_if.slave bus
);

  localparam int            KW       = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam logic [KW-1:0] KEY_LAST = KW'(KEY_LEN - 1);

  typedef enum logic [2:0] {
    KEY_LOAD,
    FILL,
    KSA,
    WAIT_CT,
    GEN_J,
    SWAP,
    KS,
    OUT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]    sbox [256];
  logic [7:0]    key  [KEY_LEN];

  // kidx is the key write pointer during KEY_LOAD and the key read pointer
  // (i mod KEY_LEN) during KSA; the two uses never overlap.
  logic [KW-1:0] kidx;
  logic [KW-1:0] kidx_inc;

  logic [7:0]    i;
  logic [7:0]    j;
  logic [7:0]    t_idx;
  logic [7:0]    ks;
  logic [7:0]    ct_reg;
  logic          ct_last_reg;
  logic          ks_phase;
  logic          init_done_r;

  logic          key_acc;
  logic          ct_acc;
  logic          pt_acc;

  logic [7:0]    j_ksa;
  logic [7:0]    j_gen;

  // Wrapping counter replaces a true modulo so KEY_LEN need not be a power of two.
  assign kidx_inc = (kidx == KEY_LAST) ? '0 : kidx + KW'(1);

  assign j_ksa = j + sbox[i] + key[kidx];
  assign j_gen = j + sbox[i];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= KEY_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Ready and valid outputs are pure decodes of the state register, so only
  // one handshake can ever be live in a given cycle.
  always_comb begin
    state_nxt     = state;
    key_acc       = 1'b0;
    ct_acc        = 1'b0;
    pt_acc        = 1'b0;
    bus.key_ready = 1'b0;
    bus.ct_ready  = 1'b0;
    bus.pt_valid  = 1'b0;
    bus.pt_last   = 1'b0;
    bus.pt_data   = 8'h00;
    bus.init_done = init_done_r;

    case (state)
      KEY_LOAD: begin
        bus.key_ready = 1'b1;
        key_acc       = bus.key_valid;
        if (key_acc && (kidx == KEY_LAST)) begin
          state_nxt = FILL;
        end
      end

      FILL: begin
        if (i == 8'hFF) begin
          state_nxt = KSA;
        end
      end

      KSA: begin
        if (i == 8'hFF) begin
          state_nxt = WAIT_CT;
        end
      end

      WAIT_CT: begin
        bus.ct_ready = 1'b1;
        ct_acc       = bus.ct_valid;
        if (ct_acc) begin
          state_nxt = GEN_J;
        end
      end

      GEN_J: begin
        state_nxt = SWAP;
      end

      SWAP: begin
        state_nxt = KS;
      end

      // Two cycles: the first registers the lookup address, the second the
      // keystream byte, keeping the double S-box read off one path.
      KS: begin
        if (ks_phase) begin
          state_nxt = OUT;
        end
      end

      OUT: begin
        bus.pt_valid = 1'b1;
        bus.pt_data  = ct_reg ^ ks;
        bus.pt_last  = ct_last_reg;
        pt_acc       = bus.pt_ready;
        if (pt_acc) begin
          state_nxt = ct_last_reg ? KEY_LOAD : WAIT_CT;
        end
      end

      default: begin
        state_nxt = KEY_LOAD;
      end
    endcase
  end

  // Index registers, captured ciphertext and keystream byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      kidx        <= '0;
      i           <= 8'h00;
      j           <= 8'h00;
      t_idx       <= 8'h00;
      ks          <= 8'h00;
      ct_reg      <= 8'h00;
      ct_last_reg <= 1'b0;
      ks_phase    <= 1'b0;
      init_done_r <= 1'b0;
    end else begin
      case (state)
        KEY_LOAD: begin
          if (key_acc) begin
            kidx <= kidx_inc;
            i    <= 8'h00;
            j    <= 8'h00;
          end
        end

        FILL: begin
          i <= i + 8'd1;
          if (i == 8'hFF) begin
            j    <= 8'h00;
            kidx <= '0;
          end
        end

        KSA: begin
          i    <= i + 8'd1;
          j    <= j_ksa;
          kidx <= kidx_inc;
          if (i == 8'hFF) begin
            j           <= 8'h00;
            kidx        <= '0;
            init_done_r <= 1'b1;
          end
        end

        WAIT_CT: begin
          if (ct_acc) begin
            ct_reg      <= bus.ct_data;
            ct_last_reg <= bus.ct_last;
            i           <= i + 8'd1;
          end
        end

        GEN_J: begin
          j <= j_gen;
        end

        SWAP: begin
          ks_phase <= 1'b0;
        end

        KS: begin
          if (!ks_phase) begin
            t_idx    <= sbox[i] + sbox[j];
            ks_phase <= 1'b1;
          end else begin
            ks       <= sbox[t_idx];
            ks_phase <= 1'b0;
          end
        end

        OUT: begin
          if (pt_acc && ct_last_reg) begin
            init_done_r <= 1'b0;
            kidx        <= '0;
            i           <= 8'h00;
            j           <= 8'h00;
          end
        end

        default: begin
        end
      endcase
    end
  end

  // Key bytes are not reset: every one is rewritten before the key schedule.
  always_ff @(posedge clk) begin
    if (rst && key_acc) begin
      key[kidx] <= bus.key_byte;
    end
  end

  // S-box storage. Not reset since FILL rewrites all 256 entries before use.
  // When the two swap indices coincide both writes carry the same value.
  always_ff @(posedge clk) begin
    if (rst) begin
      case (state)
        FILL: begin
          sbox[i] <= i;
        end

        KSA: begin
          sbox[i]     <= sbox[j_ksa];
          sbox[j_ksa] <= sbox[i];
        end

        SWAP: begin
          sbox[i] <= sbox[j];
          sbox[j] <= sbox[i];
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_decipher.sv
// tb_rc4_decipher
//   Drives two decipher instances (KEY_LEN 3 and 4) through one shared set of
//   stimulus signals; 'sel' picks which instance is active. Known-answer
//   vectors come from a table, random messages are checked against a plain
//   RC4 model, and hand-written sequences cover back-pressure, reset in the
//   middle of the key schedule, and back-to-back messages.
module tb_rc4_decipher;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic [7:0] key_byte;
  logic       key_valid;
  logic [7:0] ct_data;
  logic       ct_valid;
  logic       ct_last;
  logic       pt_ready;

  logic       key_ready;
  logic       ct_ready;
  logic [7:0] pt_data;
  logic       pt_valid;
  logic       pt_last;
  logic       init_done;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic       ct_noise;

  logic [7:0] msg_ct[$];
  logic [7:0] msg_exp[$];

  int         m_s[256];
  int         m_i;
  int         m_j;

  typedef struct packed {
    logic [7:0]  klen;
    logic [31:0] key;
    logic [7:0]  nbytes;
    logic [79:0] ct;
    logic [79:0] pt;
  } vec_t;

  vec_t vecs[3];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  rc4_decipher_if if3 ();
  rc4_decipher_if if4 ();

  assign if3.key_byte  = key_byte;
  assign if3.key_valid = key_valid & ~sel;
  assign if3.ct_data   = ct_data;
  assign if3.ct_valid  = ct_valid & ~sel;
  assign if3.ct_last   = ct_last;
  assign if3.pt_ready  = pt_ready & ~sel;

  assign if4.key_byte  = key_byte;
  assign if4.key_valid = key_valid & sel;
  assign if4.ct_data   = ct_data;
  assign if4.ct_valid  = ct_valid & sel;
  assign if4.ct_last   = ct_last;
  assign if4.pt_ready  = pt_ready & sel;

  assign key_ready = sel ? if4.key_ready : if3.key_ready;
  assign ct_ready  = sel ? if4.ct_ready  : if3.ct_ready;
  assign pt_data   = sel ? if4.pt_data   : if3.pt_data;
  assign pt_valid  = sel ? if4.pt_valid  : if3.pt_valid;
  assign pt_last   = sel ? if4.pt_last   : if3.pt_last;
  assign init_done = sel ? if4.init_done : if3.init_done;

  rc4_decipher #(.KEY_LEN(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  rc4_decipher #(.KEY_LEN(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Textbook RC4 key schedule on plain integer arrays.
  task automatic model_init(input int klen, input logic [31:0] keyv);
    int jj;
    int tmp;
    logic [7:0] kb;
    for (int n = 0; n < 256; n++) m_s[n] = n;
    jj = 0;
    for (int n = 0; n < 256; n++) begin
      kb  = keyv[8*(klen-1-(n % klen)) +: 8];
      jj  = (jj + m_s[n] + int'(kb)) % 256;
      tmp = m_s[n];
      m_s[n] = m_s[jj];
      m_s[jj] = tmp;
    end
    m_i = 0;
    m_j = 0;
  endtask

  task automatic model_next(output logic [7:0] k);
    int tmp;
    m_i = (m_i + 1) % 256;
    m_j = (m_j + m_s[m_i]) % 256;
    tmp = m_s[m_i];
    m_s[m_i] = m_s[m_j];
    m_s[m_j] = tmp;
    k = 8'(m_s[(m_s[m_i] + m_s[m_j]) % 256]);
  endtask

  task automatic send_key(input int klen, input logic [31:0] keyv);
    int wait_n;
    for (int k = 0; k < klen; k++) begin
      @(negedge clk);
      key_byte  = keyv[8*(klen-1-k) +: 8];
      key_valid = 1'b1;
      wait_n    = 0;
      while (!key_ready && wait_n < 50) begin
        @(negedge clk);
        wait_n++;
      end
      if (!key_ready) checkOutput("key_ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 key_valid = 1'b0;
    end
  endtask

  // Counts edges from the last key accept to init_done. With ct_noise set,
  // ct_valid stays high through the schedule and must never meet ct_ready.
  task automatic wait_init();
    int acc_cyc;
    int noise;
    noise = 0;
    @(negedge clk);
    acc_cyc = cyc;
    while (!init_done && (cyc - acc_cyc) < 600) begin
      if (ct_valid && ct_ready) noise++;
      if ((cyc - acc_cyc) >= 500) ct_valid = 1'b0;
      @(negedge clk);
    end
    checkOutput("init_latency", 32'(cyc - acc_cyc), 32'd512);
    if (ct_noise) begin
      ct_valid = 1'b0;
      checkOutput("ct_ignored_before_init", 32'(noise), 32'd0);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] ct, input logic last, input int hold,
                               output logic [7:0] got, output logic got_last);
    int wait_n;
    int acc_cyc;
    logic stable;
    @(negedge clk);
    ct_data  = ct;
    ct_last  = last;
    ct_valid = 1'b1;
    pt_ready = (hold == 0);
    wait_n   = 0;
    while (!ct_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    if (!ct_ready) checkOutput("ct_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    ct_valid = 1'b0;
    ct_data  = 8'($urandom);
    ct_last  = 1'($urandom);
    @(negedge clk);
    acc_cyc = cyc;
    wait_n  = 0;
    while (!pt_valid && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    checkOutput("pt_latency", 32'(cyc - acc_cyc), 32'd4);
    got      = pt_data;
    got_last = pt_last;
    if (hold > 0) begin
      stable = 1'b1;
      for (int k = 1; k < hold; k++) begin
        @(negedge clk);
        if (pt_data !== got || pt_last !== got_last || pt_valid !== 1'b1 || ct_ready !== 1'b0)
          stable = 1'b0;
      end
      checkOutput("hold_stable", 32'(stable), 32'd1);
      pt_ready = 1'b1;
    end
    @(negedge clk);
    checkOutput("pt_valid_drop", 32'(pt_valid), 32'd0);
  endtask

  task automatic run_message(input int klen, input logic [31:0] keyv, input int hold_at,
                             input int hold_len, input string name);
    logic [7:0] got;
    logic       got_last;
    logic       last;
    sel = (klen == 4);
    send_key(klen, keyv);
    wait_init();
    for (int b = 0; b < msg_ct.size(); b++) begin
      last = (b == msg_ct.size() - 1);
      applyStimulus(msg_ct[b], last, (b == hold_at) ? hold_len : 0, got, got_last);
      checkOutput({name, " pt_data"}, 32'(got), 32'(msg_exp[b]));
      checkOutput({name, " pt_last"}, 32'(got_last), 32'(last));
    end
  endtask

  task automatic load_vec(input vec_t v);
    int n;
    n = int'(v.nbytes);
    msg_ct.delete();
    msg_exp.delete();
    for (int b = 0; b < n; b++) begin
      msg_ct.push_back(v.ct[8*(n-1-b) +: 8]);
      msg_exp.push_back(v.pt[8*(n-1-b) +: 8]);
    end
  endtask

  task automatic random_message(input int klen, output logic [31:0] keyv);
    int n;
    logic [7:0] c;
    logic [7:0] k;
    keyv = $urandom;
    if (klen == 3) keyv[31:24] = 8'h00;
    n = $urandom_range(1, 12);
    model_init(klen, keyv);
    msg_ct.delete();
    msg_exp.delete();
    for (int b = 0; b < n; b++) begin
      c = 8'($urandom);
      model_next(k);
      msg_ct.push_back(c);
      msg_exp.push_back(c ^ k);
    end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    logic [31:0] rkey;
    int          rklen;

    vecs[0] = '{klen: 8'd3, key: 32'h004B6579, nbytes: 8'd9,
                ct: 80'h00BBF316E8D940AF0AD3, pt: 80'h00506C61696E74657874};
    vecs[1] = '{klen: 8'd4, key: 32'h57696B69, nbytes: 8'd5,
                ct: 80'h1021BF0420, pt: 80'h7065646961};
    vecs[2] = '{klen: 8'd3, key: 32'h004B6579, nbytes: 8'd10,
                ct: 80'h0, pt: 80'hEB9F7781B734CA72A719};

    rst       = 1'b0;
    sel       = 1'b0;
    key_byte  = 8'h00;
    key_valid = 1'b0;
    ct_data   = 8'h00;
    ct_valid  = 1'b0;
    ct_last   = 1'b0;
    pt_ready  = 1'b1;
    ct_noise  = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset key_ready", 32'(key_ready), 32'd1);
    checkOutput("reset init_done", 32'(init_done), 32'd0);
    checkOutput("reset ct_ready", 32'(ct_ready), 32'd0);
    checkOutput("reset pt_valid", 32'(pt_valid), 32'd0);
    checkOutput("reset pt_data", 32'(pt_data), 32'd0);
    rst = 1'b1;

    $display("[TB] known-answer vectors");
    for (int v = 0; v < 3; v++) begin
      load_vec(vecs[v]);
      run_message(int'(vecs[v].klen), vecs[v].key, -1, 0, $sformatf("vec%0d", v));
    end

    $display("[TB] back-pressure on Plaintext message");
    load_vec(vecs[0]);
    run_message(3, vecs[0].key, 4, 7, "hold");

    $display("[TB] reset during key schedule");
    sel = 1'b0;
    send_key(3, vecs[0].key);
    repeat (300) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("midksa key_ready", 32'(key_ready), 32'd1);
    checkOutput("midksa init_done", 32'(init_done), 32'd0);
    checkOutput("midksa ct_ready", 32'(ct_ready), 32'd0);
    checkOutput("midksa pt_valid", 32'(pt_valid), 32'd0);
    checkOutput("midksa pt_last", 32'(pt_last), 32'd0);
    checkOutput("midksa pt_data", 32'(pt_data), 32'd0);
    ct_noise = 1'b1;
    ct_data  = 8'h5A;
    ct_last  = 1'b1;
    ct_valid = 1'b1;
    load_vec(vecs[0]);
    run_message(3, vecs[0].key, -1, 0, "after_reset");
    ct_noise = 1'b0;

    $display("[TB] randomized messages against the model");
    for (int t = 0; t < 6; t++) begin
      rklen = (t % 2 == 1) ? 4 : 3;
      random_message(rklen, rkey);
      run_message(rklen, rkey, $urandom_range(0, 3), $urandom_range(0, 4),
                  $sformatf("rand%0d", t));
    end

    $display("[TB] back-to-back messages, Plaintext then Wiki");
    load_vec(vecs[0]);
    run_message(3, vecs[0].key, -1, 0, "b2b_first");
    random_message(4, rkey);
    run_message(4, rkey, -1, 0, "b2b_prev4");
    load_vec(vecs[1]);
    run_message(4, vecs[1].key, -1, 0, "b2b_wiki");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
